vram_fill: RTL and testbench

VRAM_FILL -- requirements
Module: vram_fill

---
 rtl/vram_fill_pkg.sv | 24 ++
 rtl/vram_fill.sv | 165 ++++++++++++++++
 tb/tb_vram_fill.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_fill_pkg.sv
// Shared screen package for the VRAM fill engine: memory geometry, field
// widths, the fill FSM state encoding and the wrapping address helper.
package vram_fill_pkg;

  localparam int VRAM_WORDS = 8192;
  localparam int ADDR_W     = 13;
  localparam int DATA_W     = 16;
  localparam int COUNT_W    = 14;  // one wider than ADDR_W so 8192 fits

  typedef logic [ADDR_W-1:0] vaddr_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fill_state_e;

  // Start address plus offset, modulo the VRAM size. The address width
  // equals log2(VRAM_WORDS), so dropping the carry is the wrap.
  function automatic vaddr_t wrap_addr(input vaddr_t base, input vaddr_t offset);
    return vaddr_t'(base + offset);
  endfunction

endpackage

// File: rtl/vram_fill.sv
// VRAM fill engine sharing the VRAM CPU-side port with the CPU.
// The CPU owns the port by default. A pending fill takes the port whenever
// the CPU is idle, or after STARVE_MAX consecutive granted CPU writes.
// Optional build macro: VRAM_FILL_ABORT_EN adds the fill_abort input.
module vram_fill
  import vram_fill_pkg::*;
#(
  parameter int STARVE_MAX = 8
) (
  input  logic               clk,
  input  logic               resetn,
  // CPU side
  input  logic               cpu_load,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [DATA_W-1:0]  cpu_din,
  output logic               cpu_busy,
  output logic [DATA_W-1:0]  cpu_dout,
  // Fill command
  input  logic               fill_start,
  input  logic [ADDR_W-1:0]  fill_base,
  input  logic [COUNT_W-1:0] fill_count,
  input  logic [DATA_W-1:0]  fill_pattern,
`ifdef VRAM_FILL_ABORT_EN
  input  logic               fill_abort,
`endif
  output logic               fill_busy,
  output logic               fill_done,
  // VRAM CPU-side port
  output logic               vram_load,
  output logic [ADDR_W-1:0]  vram_addr,
  output logic [DATA_W-1:0]  vram_din,
  input  logic               vram_busy,
  input  logic [DATA_W-1:0]  vram_dout
);

  localparam int STARVE_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  fill_state_e          state_q,     state_d;
  logic [ADDR_W-1:0]    base_q,      base_d;
  logic [COUNT_W-1:0]   count_q,     count_d;
  logic [DATA_W-1:0]    pattern_q,   pattern_d;
  logic [ADDR_W-1:0]    offset_q,    offset_d;
  logic [STARVE_W-1:0]  starve_q,    starve_d;
  logic                 fill_busy_q, fill_busy_d;
  logic                 fill_done_q, fill_done_d;

  logic abort_req;
  logic fill_grant;
  logic fill_accept;
  logic cpu_accept;
  logic last_word;

`ifdef VRAM_FILL_ABORT_EN
  assign abort_req = fill_abort;
`else
  assign abort_req = 1'b0;
`endif

  // The fill engine is never granted while reset is held, so the CPU keeps
  // a live passthrough even though state_q only clears on the next edge.
  // An abort cycle also withholds the grant, suppressing that fill write.
  assign fill_grant  = resetn && (state_q == ST_RUN) && !abort_req &&
                       (!cpu_load || (starve_q == STARVE_LIM));
  assign fill_accept = fill_grant && !vram_busy;
  assign cpu_accept  = !fill_grant && cpu_load && !vram_busy;
  assign last_word   = ({1'b0, offset_q} == (count_q - 14'd1));

  // Port grant mux: CPU passthrough unless the fill engine holds the port.
  always_comb begin
    vram_load = cpu_load;
    vram_addr = cpu_addr;
    vram_din  = cpu_din;
    if (fill_grant) begin
      vram_load = 1'b1;
      vram_addr = wrap_addr(base_q, offset_q);
      vram_din  = pattern_q;
    end
  end

  // The CPU stalls on a VRAM stall, or when it wants the port but lost it.
  // Read data is passed straight through; during a fill grant it belongs
  // to the fill address and the stalled CPU discards it.
  assign cpu_busy  = vram_busy | (fill_grant & cpu_load);
  assign cpu_dout  = vram_dout;
  assign fill_busy = fill_busy_q;
  assign fill_done = fill_done_q;

  // Next-state logic for the fill FSM, its datapath and the starve counter.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    base_d      = base_q;
    count_d     = count_q;
    pattern_d   = pattern_q;
    offset_d    = offset_q;
    starve_d    = starve_q;
    fill_done_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (fill_start) begin
          if (fill_count != '0) begin
            base_d    = fill_base;
            count_d   = fill_count;
            pattern_d = fill_pattern;
            offset_d  = '0;
            state_d   = ST_RUN;
          end else begin
            // Empty fill: nothing to write, just acknowledge it.
            fill_done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (abort_req) begin
          state_d = ST_DONE;
        end else if (fill_accept) begin
          offset_d = offset_q + 1'b1;
          starve_d = '0;
          if (last_word) state_d = ST_DONE;
        end else if (cpu_accept && (starve_q != STARVE_LIM)) begin
          starve_d = starve_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // The starve count only means something while a fill is running.
    if (state_d != ST_RUN) starve_d = '0;

    fill_busy_d = (state_d != ST_IDLE);
    if (state_d == ST_DONE) fill_done_d = 1'b1;
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge like any other input, so it
    // sits inside the edge-triggered branch rather than the sensitivity list.
    if (!resetn) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      count_q     <= '0;
      pattern_q   <= '0;
      offset_q    <= '0;
      starve_q    <= '0;
      fill_busy_q <= 1'b0;
      fill_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      base_q      <= base_d;
      count_q     <= count_d;
      pattern_q   <= pattern_d;
      offset_q    <= offset_d;
      starve_q    <= starve_d;
      fill_busy_q <= fill_busy_d;
      fill_done_q <= fill_done_d;
    end
  end

endmodule

// File: tb/tb_vram_fill.sv
// Self-checking bench for vram_fill (default build, no abort port).
// A queue-based model predicts the port owner and all outputs every cycle;
// directed scenarios add hand-computed checks on the resulting VRAM image.
module tb_vram_fill;
  import vram_fill_pkg::*;

  localparam int STARVE = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cpu_load;
  logic [12:0] cpu_addr;
  logic [15:0] cpu_din;
  logic        cpu_busy;
  logic [15:0] cpu_dout;
  logic        fill_start;
  logic [12:0] fill_base;
  logic [13:0] fill_count;
  logic [15:0] fill_pattern;
  logic        fill_busy;
  logic        fill_done;
  logic        vram_load;
  logic [12:0] vram_addr;
  logic [15:0] vram_din;
  logic        vram_busy;
  logic [15:0] vram_dout;

  always #5 clk = ~clk;

  vram_fill #(.STARVE_MAX(STARVE)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .cpu_load     (cpu_load),
    .cpu_addr     (cpu_addr),
    .cpu_din      (cpu_din),
    .cpu_busy     (cpu_busy),
    .cpu_dout     (cpu_dout),
    .fill_start   (fill_start),
    .fill_base    (fill_base),
    .fill_count   (fill_count),
    .fill_pattern (fill_pattern),
    .fill_busy    (fill_busy),
    .fill_done    (fill_done),
    .vram_load    (vram_load),
    .vram_addr    (vram_addr),
    .vram_din     (vram_din),
    .vram_busy    (vram_busy),
    .vram_dout    (vram_dout)
  );

  // ---------------- VRAM memory and write log ----------------
  logic [15:0] mem [0:8191];
  assign vram_dout = mem[vram_addr];

  bit          wr_pend = 1'b0;
  logic [12:0] wr_addr;
  logic [15:0] wr_din;
  logic [12:0] log_addr[$];
  logic [15:0] log_din[$];
  int          wr_cnt   = 0;
  int          done_cnt = 0;
  bit          cmp_en   = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pending fill = queue of the addresses still to be written, in order.
  logic [12:0] m_q[$];
  logic [15:0] m_pat  = '0;
  bit          m_run  = 1'b0;
  bit          m_done = 1'b0;
  bit          m_zero = 1'b0;
  int          m_streak = 0;

  function automatic bit m_grant();
    return (resetn === 1'b1) && m_run && (!cpu_load || (m_streak == STARVE));
  endfunction

  always @(posedge clk) begin : model_upd
    bit g;
    bit was_done;
    g        = m_grant();
    was_done = m_done;
    m_done   = 1'b0;
    m_zero   = 1'b0;
    if (resetn !== 1'b1) begin
      m_q.delete();
      m_run    = 1'b0;
      m_streak = 0;
    end else if (m_run) begin
      if (g && !vram_busy) begin
        void'(m_q.pop_front());
        m_streak = 0;
        if (m_q.size() == 0) begin
          m_run  = 1'b0;
          m_done = 1'b1;
        end
      end else if (!g && cpu_load && !vram_busy) begin
        m_streak++;
      end
    end else if (!was_done && fill_start) begin
      if (fill_count == 0) begin
        m_zero = 1'b1;
      end else begin
        for (int i = 0; i < int'(fill_count); i++)
          m_q.push_back(13'((int'(fill_base) + i) % VRAM_WORDS));
        m_pat    = fill_pattern;
        m_run    = 1'b1;
        m_streak = 0;
      end
    end
  end

  // Apply the write captured at the preceding falling edge.
  always @(posedge clk) begin
    if (wr_pend) begin
      mem[wr_addr] = wr_din;
      log_addr.push_back(wr_addr);
      log_din.push_back(wr_din);
      wr_cnt++;
    end
  end

  // Single compare process plus write/done monitor, on the falling edge.
  always @(negedge clk) begin : compare
    bit          g;
    logic        e_load;
    logic [12:0] e_addr;
    logic [15:0] e_din;
    wr_pend = (vram_load === 1'b1) && (vram_busy === 1'b0);
    wr_addr = vram_addr;
    wr_din  = vram_din;
    if (fill_done === 1'b1) done_cnt++;
    if (cmp_en) begin
      g      = m_grant();
      e_load = g ? 1'b1 : cpu_load;
      e_addr = g ? m_q[0] : cpu_addr;
      e_din  = g ? m_pat : cpu_din;
      check("vram_load", vram_load, e_load);
      if (e_load) begin
        check("vram_addr", vram_addr, e_addr);
        check("vram_din", vram_din, e_din);
      end
      check("cpu_busy", cpu_busy, vram_busy | (g & cpu_load));
      check("cpu_dout", cpu_dout, mem[e_addr]);
      check("fill_busy", fill_busy, m_run | m_done);
      check("fill_done", fill_done, m_done | m_zero);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_fill(input logic [12:0] b, input logic [13:0] c, input logic [15:0] p);
    fill_base    = b;
    fill_count   = c;
    fill_pattern = p;
    fill_start   = 1'b1;
    step();
    fill_start   = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    int k;
    d0 = done_cnt;
    k  = 0;
    while (done_cnt == d0 && k < budget) begin
      step();
      k++;
    end
    check({name, " done within budget"}, 32'(done_cnt > d0), 32'd1);
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_din.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int w0, d0, bad, n;
    int fpos[$];

    for (int i = 0; i < VRAM_WORDS; i++) mem[i] = 16'(i) ^ 16'h5A5A;

    resetn       = 1'b0;
    cpu_load     = 1'b1;
    cpu_addr     = 13'd77;
    cpu_din      = 16'hCAFE;
    fill_start   = 1'b0;
    fill_base    = '0;
    fill_count   = '0;
    fill_pattern = '0;
    vram_busy    = 1'b0;
    step(2);
    // Reset state and CPU passthrough during reset.
    check("reset fill_busy", fill_busy, 0);
    check("reset fill_done", fill_done, 0);
    check("reset vram_load", vram_load, 1);
    check("reset vram_addr", vram_addr, 77);
    check("reset vram_din", vram_din, 16'hCAFE);
    cpu_load = 1'b0;
    resetn   = 1'b1;
    cmp_en   = 1'b1;
    step(2);

    // Zero count: no write, fill_done one cycle later, never busy.
    w0 = wr_cnt;
    d0 = done_cnt;
    start_fill(13'd5, 14'd0, 16'h1111);
    check("zero fill_done", fill_done, 1);
    check("zero fill_busy", fill_busy, 0);
    step(2);
    check("zero writes", wr_cnt - w0, 0);
    check("zero done pulses", done_cnt - d0, 1);

    // Full clear of all 8192 words.
    clear_log();
    w0 = wr_cnt;
    d0 = done_cnt;
    start_fill(13'd0, 14'd8192, 16'h0000);
    wait_done("clear", 9000);
    check("clear fill_busy after done", fill_busy, 0);
    check("clear writes", wr_cnt - w0, 8192);
    bad = 0;
    for (int i = 0; i < log_addr.size(); i++) if (log_addr[i] != 13'(i)) bad++;
    check("clear address order", bad, 0);
    bad = 0;
    for (int i = 0; i < VRAM_WORDS; i++) if (mem[i] != 16'h0000) bad++;
    check("clear nonzero words", bad, 0);
    step(2);
    check("clear done pulses", done_cnt - d0, 1);

    // Wrap-around: 8190, 8191, 0, 1.
    clear_log();
    start_fill(13'd8190, 14'd4, 16'hFFFF);
    wait_done("wrap", 30);
    check("wrap write count", log_addr.size(), 4);
    if (log_addr.size() == 4) begin
      check("wrap addr0", log_addr[0], 8190);
      check("wrap addr1", log_addr[1], 8191);
      check("wrap addr2", log_addr[2], 0);
      check("wrap addr3", log_addr[3], 1);
    end
    check("wrap mem8189", mem[8189], 16'h0000);
    check("wrap mem2", mem[2], 16'h0000);
    check("wrap mem0", mem[0], 16'hFFFF);

    // Starvation: CPU writes every cycle; the fill takes every 9th slot.
    // Log entry 0 is the CPU write in the start cycle, then 8 CPU, 1 fill.
    clear_log();
    cpu_load = 1'b1;
    cpu_addr = 13'd4000;
    cpu_din  = 16'h1234;
    start_fill(13'd300, 14'd3, 16'hA5A5);
    wait_done("starve", 100);
    cpu_load = 1'b0;
    step();
    for (int i = 0; i < log_din.size(); i++) if (log_din[i] == 16'hA5A5) fpos.push_back(i);
    check("starve fill writes", fpos.size(), 3);
    if (fpos.size() == 3) begin
      check("starve fill pos0", fpos[0], 9);
      check("starve fill pos1", fpos[1], 18);
      check("starve fill pos2", fpos[2], 27);
      check("starve fill addr2", log_addr[fpos[2]], 302);
    end
    check("starve cpu word", mem[4000], 16'h1234);

    // VRAM stall mid-fill, with an ignored fill_start during the stall.
    clear_log();
    start_fill(13'd1000, 14'd20, 16'h3C3C);
    step(5);
    vram_busy    = 1'b1;
    fill_base    = 13'd2000;
    fill_count   = 14'd5;
    fill_start   = 1'b1;
    n = 0;
    repeat (5) begin
      #2;
      if (cpu_busy === 1'b1) n++;
      @(posedge clk);
      #1;
      fill_start = 1'b0;
    end
    vram_busy = 1'b0;
    check("stall cpu_busy cycles", n, 5);
    wait_done("stall", 60);
    step(3);
    check("stall write count", log_addr.size(), 20);
    bad = 0;
    for (int i = 0; i < log_addr.size(); i++) if (log_addr[i] != 13'(1000 + i)) bad++;
    check("stall address sequence", bad, 0);
    check("stall ignored start", mem[2000], 16'h0000);

    // Reset at offset 100 of a 200-word fill.
    clear_log();
    d0 = done_cnt;
    start_fill(13'd0, 14'd200, 16'h7777);
    n = 0;
    while (log_addr.size() < 100 && n < 300) begin
      step();
      n++;
    end
    check("reset-mid reached offset 100", log_addr.size(), 100);
    resetn   = 1'b0;
    cpu_load = 1'b1;
    cpu_addr = 13'd5000;
    cpu_din  = 16'hBEEF;
    #2;
    check("reset-mid vram_load", vram_load, 1);
    check("reset-mid vram_addr", vram_addr, 5000);
    step();
    check("reset-mid fill_busy", fill_busy, 0);
    resetn   = 1'b1;
    cpu_load = 1'b0;
    step(5);
    check("reset-mid no fill_done", done_cnt - d0, 0);
    check("reset-mid mem99", mem[99], 16'h7777);
    check("reset-mid mem100", mem[100], 16'h0000);
    check("reset-mid cpu word", mem[5000], 16'hBEEF);

    // A fresh fill runs normally after the abandoned one.
    clear_log();
    start_fill(13'd50, 14'd2, 16'h0F0F);
    wait_done("recover", 20);
    check("recover write count", log_addr.size(), 2);
    check("recover mem51", mem[51], 16'h0F0F);

    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
